// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive-side buffer behind the UART core.
// A small capture FSM moves each {parity_error, rx_data} into a circular
// FIFO and holds rx_flag_clr until the core drops rx_flag. The consumer
// side is a first-word-fall-through valid/ready port.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  rx_flag,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  parity_error,
  output logic                  rx_flag_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_perr,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  input  logic                  ovf_clr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CLR  = 1'b1;

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [0:0]            state;
  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic push_req;
  logic pop;
  logic full;
  logic push;
  logic drop;

  // Push/pop qualification; a pop on the same edge frees the slot for a push when full
  always_comb begin
    push_req = (state == IDLE) && rx_flag;
    pop      = rd_valid && rd_ready;
    full     = (count == FULL_COUNT);
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  // Capture FSM: one capture per flag assertion, clear held until flag drops
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (rx_flag) state <= CLR;
        CLR:     if (!rx_flag) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign rx_flag_clr = (state == CLR);

  // FIFO storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {parity_error, rx_data};
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (push && !pop) begin
        count <= count + (ADDR_WIDTH + 1)'(1);
      end else if (pop && !push) begin
        count <= count - (ADDR_WIDTH + 1)'(1);
      end
    end
  end

  // Sticky overflow; a drop on the same edge as a clear wins
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  assign rd_valid = (count != '0);

  // Head entry presented from registered state only, zero when empty
  always_comb begin
    rd_data = '0;
    rd_perr = 1'b0;
    if (rd_valid) begin
      {rd_perr, rd_data} = mem[rd_ptr];
    end
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side buffer placed directly downstream of the UART core. It watches the core's `rx_flag`, captures `rx_data` and `parity_error` into a FIFO, and drives `rx_flag_clr` to release the core for the next frame. The FIFO presents bytes to the consumer through a first-word-fall-through valid/ready read port, with an occupancy count and a sticky overflow indication.

## Interface
- `DATA_WIDTH`, default 8: width of a received byte; matches the core's `UART_DATA_WIDTH`.
- `DEPTH`, default 8: number of FIFO entries. Must be a power of two and at least 2.
- `ADDR_WIDTH`, default $clog2(DEPTH): local width of the FIFO pointers.
- `clk`, in, 1: single clock, shared with the UART core.
- `n_rst`, in, 1: asynchronous, active-low reset.
- `rx_flag`, in, 1: byte-available flag from the UART core.
- `rx_data`, in, DATA_WIDTH: received byte from the UART core.
- `parity_error`, in, 1: parity status of the received byte, from the UART core.
- `rx_flag_clr`, out, 1: flag-clear request to the UART core. Registered.
- `rd_data`, out, DATA_WIDTH: byte at the FIFO head. Reads 0 when the FIFO is empty.
- `rd_perr`, out, 1: parity-error bit stored with the head byte. Reads 0 when empty.
- `rd_valid`, out, 1: FIFO is not empty.
- `rd_ready`, in, 1: consumer accepts the head entry.
- `count`, out, ADDR_WIDTH+1: number of occupied entries, 0..DEPTH.
- `overflow`, out, 1: sticky flag; at least one byte was dropped because the FIFO was full.
- `ovf_clr`, in, 1: clears `overflow`.

## Operation
- **Capture FSM**, two states: IDLE and CLR.
  - **IDLE**, on an edge with `rx_flag`=1:
    - write {`parity_error`, `rx_data`} into the FIFO, unless the FIFO is full with no pop on the same edge; in that case drop the byte and set `overflow`.
    - go to CLR.
  - **CLR**: `rx_flag_clr`=1.
    - Stay in CLR while `rx_flag`=1.
    - On an edge with `rx_flag`=0, go to IDLE; `rx_flag_clr` returns to 0 after that edge.
  - `rx_flag_clr` is a Moore output and equals (state==CLR).
  - Holding the clear until the flag drops absorbs the core's internal one-flop sync on the clear. The FSM never captures the same byte twice.
- **FIFO storage**:
  - Circular buffer of DEPTH entries, each DATA_WIDTH+1 bits wide.
  - Write pointer and read pointer are ADDR_WIDTH bits and wrap from DEPTH-1 to 0.
  - `count` is tracked explicitly.
  - Storage is not reset.
- **Read port**:
  - `rd_valid` = (`count` != 0).
  - `rd_data`/`rd_perr` show the head entry, or 0 when empty.
  - A pop occurs on any edge where `rd_valid`&`rd_ready`=1. `rd_ready` has no effect when the FIFO is empty.
- **Simultaneous push and pop**:
  - Both happen and `count` is unchanged.
  - When full, a push on the same edge as a pop is accepted, with no overflow.
  - When empty, the pushed byte is not visible until after the write edge; there is no write-to-read bypass.
- **`count` update**: +1 on push only, -1 on pop only, otherwise unchanged.
- **Overflow**:
  - Set on a dropped byte.
  - Cleared on an edge with `ovf_clr`=1.
  - If set and clear occur on the same edge, set wins.
- **Reset** (asynchronous, `n_rst`=0):
  - state=IDLE, pointers=0, `count`=0.
  - `rd_valid`=0, `rd_data`=0, `rd_perr`=0, `rx_flag_clr`=0, `overflow`=0.
  - Reset mid-frame or in CLR abandons the clear; the core is reset by the same `n_rst`.

## Timing
- **Capture**:
  - Edge E samples `rx_flag`=1 in IDLE: the entry is written at E, `count` increments at E, and `rx_flag_clr`=1 from E.
  - The core drops `rx_flag` two edges later (E+2).
  - The FSM samples `rx_flag`=0 at E+3 and returns to IDLE; `rx_flag_clr`=0 after E+3.
- **Empty-to-valid latency**: `rd_valid` rises in the cycle after the write edge.
- **Pop**: `rd_data` advances to the next entry, or drops to 0, in the cycle after the pop edge.
- **Throughput**: one capture per flag assertion. The core cannot raise a new `rx_flag` before the clear completes, because it gates frame start on the flag.
- **Outputs**: all outputs are registered or derived only from registered state; there are no combinational paths from inputs to outputs.

## Test plan
- **Single byte**:
  - Stimulus: reset; `rx_flag`=1 with `rx_data`=0xA5, `parity_error`=0; core model drops the flag 2 cycles after `rx_flag_clr`.
  - Required: exactly one entry; `count`=1; `rd_valid`=1; `rd_data`=0xA5; `rx_flag_clr` high for exactly 3 cycles.
  - Then `rd_ready`=1 for one cycle: `count`=0, `rd_valid`=0, `rd_data`=0.
- **Fill and wrap**:
  - Stimulus: push 0x00..0x07 with `DEPTH`=8; pop 3; push 0x08..0x0A; drain.
  - Required: `count` reaches 8 then 5 then 8; pop order 0x00..0x0A; `overflow`=0 throughout.
- **Overflow**:
  - Stimulus: with the FIFO full, push 0xFF without popping.
  - Required: 0xFF is dropped, `overflow`=1, `count`=8, `rx_flag_clr` still issued.
  - Then `ovf_clr`=1: `overflow`=0.
  - Then a push coinciding with a pop while full: accepted, `overflow` stays 0.
- **Parity tag**:
  - Stimulus: push 0x3C with `parity_error`=1, then 0x3D with `parity_error`=0.
  - Required: `rd_perr` reads 1 then 0, aligned to the matching bytes.
- **Stuck flag**:
  - Stimulus: hold `rx_flag`=1 for 10 cycles after `rx_flag_clr` rises.
  - Required: exactly one entry written; `rx_flag_clr` stays 1 until the flag drops.
- **Reset mid-operation**:
  - Stimulus: `count`=4 and FSM in CLR; assert `n_rst`=0 asynchronously between edges.
  - Required: `rx_flag_clr`, `rd_valid`, `count` and `overflow` go to 0 immediately, before the next clock edge; after release, the next push reads back first.
